// File: rtl/prescaled_mod_counter.sv
// -----------------------------------------------------------------------------
// prescaled_mod_counter
//
// Modulo up/down counter advanced by an internal prescaler. The prescaler
// produces a one-cycle step enable, never a derived clock, so everything runs
// in the single Clk domain. Count, Tick, Wrap and Done are all registered.
//
// Priority, highest first: Reset > Load > step > hold.
//
// With PMC_ONESHOT_EN defined, a step that would wrap instead holds Count at
// its terminal value and sets the sticky Done flag; otherwise Done is tied 0.
//
// Cascading: drive an upper stage's En from a lower stage's Wrap, DIV_N=1.
// -----------------------------------------------------------------------------
module prescaled_mod_counter #(
  parameter int CNT_W = 4,
  parameter int MOD   = 10,
  parameter int DIV_W = 27,
  parameter int DIV_N = 100_000_000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [CNT_W-1:0] Load_Val,
  output logic [CNT_W-1:0] Count,
  output logic             Tick,
  output logic             Wrap,
  output logic             Done
);

  localparam int LW = CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MOD - 1);
  localparam logic [LW-1:0]    MOD_WIDE = LW'(MOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);

  logic [DIV_W-1:0] div;
  logic             div_last;
  logic             step;
  logic             at_term;
  logic             hold_step;
  logic [CNT_W-1:0] load_sat;
  logic [CNT_W-1:0] wrap_val;

  assign div_last = (div == DIV_LAST);
  assign step     = En && div_last;

  assign at_term  = Up ? (Count == CNT_MAX) : (Count == '0);
  assign wrap_val = Up ? '0 : CNT_MAX;

  // Compare one bit wider so a modulus of 2**CNT_W is representable.
  assign load_sat = ({1'b0, Load_Val} >= MOD_WIDE) ? CNT_MAX : Load_Val;

`ifdef PMC_ONESHOT_EN
  assign hold_step = Done || at_term;

  always_ff @(posedge Clk) begin
    if (Reset || Load) begin
      Done <= 1'b0;
    end else if (step && at_term) begin
      Done <= 1'b1;
    end
  end
`else
  assign hold_step = 1'b0;
  assign Done      = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div   <= '0;
      Count <= '0;
      Tick  <= 1'b0;
      Wrap  <= 1'b0;
    end else if (Load) begin
      div   <= '0;
      Count <= load_sat;
      Tick  <= 1'b0;
      Wrap  <= 1'b0;
    end else begin
      Tick <= 1'b0;
      Wrap <= 1'b0;
      if (En) begin
        if (div_last) begin
          div  <= '0;
          Tick <= 1'b1;
          if (!hold_step) begin
            if (at_term) begin
              Count <= wrap_val;
              Wrap  <= 1'b1;
            end else if (Up) begin
              Count <= Count + CNT_W'(1);
            end else begin
              Count <= Count - CNT_W'(1);
            end
          end
        end else begin
          div <= div + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prescaled_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_prescaled_mod_counter
//
// Directed bench for prescaled_mod_counter with CNT_W=4, MOD=10, DIV_W=3,
// DIV_N=4. Inputs change 1 time unit after a rising edge; outputs are sampled
// at the same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_prescaled_mod_counter;

   localparam int CNT_W = 4;
   localparam int MOD   = 10;
   localparam int DIV_W = 3;
   localparam int DIV_N = 4;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             En;
   logic             Up;
   logic             Load;
   logic [CNT_W-1:0] Load_Val;
   logic [CNT_W-1:0] Count;
   logic             Tick;
   logic             Wrap;
   logic             Done;

   int n_checks = 0;
   int n_fails  = 0;

   prescaled_mod_counter #(
      .CNT_W (CNT_W),
      .MOD   (MOD),
      .DIV_W (DIV_W),
      .DIV_N (DIV_N)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .En       (En),
      .Up       (Up),
      .Load     (Load),
      .Load_Val (Load_Val),
      .Count    (Count),
      .Tick     (Tick),
      .Wrap     (Wrap),
      .Done     (Done)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   // Checks every output after one edge.
   task automatic cyc_chk(input string tag, input int cnt, input bit tk, input bit wr, input bit dn);
      cyc();
      check({tag, ".count"}, 32'(Count), 32'(cnt));
      check({tag, ".tick"},  32'(Tick),  32'(tk));
      check({tag, ".wrap"},  32'(Wrap),  32'(wr));
      check({tag, ".done"},  32'(Done),  32'(dn));
   endtask

   // One full prescaler period starting from Div=0: three quiet edges, then
   // a step edge with the given result.
   task automatic period(input string tag, input int prev, input int cnt, input bit wr, input bit dn);
      for (int i = 0; i < DIV_N - 1; i++) cyc_chk({tag, ".quiet"}, prev, 1'b0, 1'b0, dn);
      cyc_chk({tag, ".step"}, cnt, 1'b1, wr, dn);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      cyc();
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; En = 1'b0; Up = 1'b1; Load = 1'b0; Load_Val = '0;

      // Reset state
      cyc_chk("reset", 0, 1'b0, 1'b0, 1'b0);

      // 1: count up, wrap on the 10th step (40th enabled cycle)
      Reset = 1'b0; En = 1'b1; Up = 1'b1;
      for (int k = 1; k <= 10; k++) period("up", k - 1, k % MOD, k == 10, 1'b0);

      // 2: count down from reset, first step wraps to 9
      do_reset();
      check("dn_rst.count", 32'(Count), 32'd0);
      Up = 1'b0;
      period("dn1", 0, 9, 1'b1, 1'b0);
      period("dn2", 9, 8, 1'b0, 1'b0);

      // 3: disable at Div=2 for three cycles; step arrives three cycles late
      cyc_chk("en.d1", 8, 1'b0, 1'b0, 1'b0);
      cyc_chk("en.d2", 8, 1'b0, 1'b0, 1'b0);
      En = 1'b0;
      for (int i = 0; i < 3; i++) cyc_chk("en.off", 8, 1'b0, 1'b0, 1'b0);
      En = 1'b1;
      cyc_chk("en.d3", 8, 1'b0, 1'b0, 1'b0);
      cyc_chk("en.step", 7, 1'b1, 1'b0, 1'b0);

      // 4: load on a step edge wins; next step a full period later
      Up = 1'b1;
      for (int i = 0; i < DIV_N - 1; i++) cyc_chk("ld.pre", 7, 1'b0, 1'b0, 1'b0);
      Load = 1'b1; Load_Val = 4'd7;
      cyc_chk("ld.edge", 7, 1'b0, 1'b0, 1'b0);
      Load = 1'b0;
      period("ld.next", 7, 8, 1'b0, 1'b0);
      // Saturating load, applied with the prescaler disabled
      En = 1'b0; Load = 1'b1; Load_Val = 4'd12;
      cyc_chk("ld.sat", 9, 1'b0, 1'b0, 1'b0);
      Load_Val = 4'd15;
      cyc_chk("ld.sat15", 9, 1'b0, 1'b0, 1'b0);
      Load_Val = 4'd10;
      cyc_chk("ld.sat10", 9, 1'b0, 1'b0, 1'b0);
      Load = 1'b0; En = 1'b1;
      period("ld.wrap", 9, 0, 1'b1, 1'b0);

      // 5: reset mid-period overrides Load and En
      Load = 1'b1; Load_Val = 4'd4;
      cyc();
      Load = 1'b0;
      period("rs.pre", 4, 5, 1'b0, 1'b0);
      cyc_chk("rs.d1", 5, 1'b0, 1'b0, 1'b0);
      cyc_chk("rs.d2", 5, 1'b0, 1'b0, 1'b0);
      Reset = 1'b1; Load = 1'b1; Load_Val = 4'd7;
      cyc_chk("rs.edge", 0, 1'b0, 1'b0, 1'b0);
      Reset = 1'b0; Load = 1'b0;
      period("rs.lat", 0, 1, 1'b0, 1'b0);

      // 6: terminal step behaviour at Count=9 counting up
      Load = 1'b1; Load_Val = 4'd9;
      cyc();
      Load = 1'b0;
`ifdef PMC_ONESHOT_EN
      period("os.hit", 9, 9, 1'b0, 1'b1);
      period("os.hold", 9, 9, 1'b0, 1'b1);
      Up = 1'b0;
      period("os.dir", 9, 9, 1'b0, 1'b1);
      Load = 1'b1; Load_Val = 4'd0;
      cyc_chk("os.clr", 0, 1'b0, 1'b0, 1'b0);
      Load = 1'b0; Up = 1'b1;
      period("os.run", 0, 1, 1'b0, 1'b0);
`else
      period("wr.hit", 9, 0, 1'b1, 1'b0);
      period("wr.next", 0, 1, 1'b0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
